key_click_decode: RTL and testbench



---
 rtl/key_pkg.sv | 19 +
 rtl/gap_timer.sv | 36 +++
 rtl/key_click_decode.sv | 83 ++++++++
 tb/tb_key_click_decode.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// Module   : key_pkg
// Purpose  : Shared types and constants for the key debounce / click decode path.
// Revision : 1.0 - initial release
// ============================================================================
package key_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int c_gap_time_default = 9000;
    // Short window used by the benches so whole click sequences fit in a few cycles.
    localparam int c_gap_time_sim     = 8;

endpackage : key_pkg
`default_nettype wire

// File: rtl/gap_timer.sv
`default_nettype none
// ============================================================================
// Module   : gap_timer
// Purpose  : Clearable up-counter timing the inter-click window, flags last cycle.
// Revision : 1.0 - initial release
// ============================================================================
module gap_timer #(
    parameter int GAP_TIME = 9000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int                   c_cnt_w = (GAP_TIME > 2) ? $clog2(GAP_TIME) : 1;
    localparam logic [c_cnt_w-1:0]   c_last  = c_cnt_w'(GAP_TIME - 1);

    logic [c_cnt_w-1:0] r_count;

    // Clear has priority so the count never steps past the terminal value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc = (r_count == c_last);

endmodule : gap_timer
`default_nettype wire

// File: rtl/key_click_decode.sv
`default_nettype none
// ============================================================================
// Module   : key_click_decode
// Purpose  : Classifies debounced press pulses into single / double click events.
// Revision : 1.0 - initial release
// ============================================================================
module key_click_decode
    import key_pkg::*;
#(
    parameter int GAP_TIME = c_gap_time_default,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_pulse,
    output logic             single_click,
    output logic             double_click,
    output logic             busy,
    output logic [CNT_W-1:0] click_cnt
);

    state_t             r_state;
    logic               r_single;
    logic               r_double;
    logic [CNT_W-1:0]   r_click_cnt;
    logic               w_tc;
    logic               w_in_wait;
    logic               w_clr;

    assign w_in_wait = (r_state == WAIT);
    // Restart the window from zero on entry and whenever it closes.
    assign w_clr     = !w_in_wait || key_pulse || w_tc;

    gap_timer #(
        .GAP_TIME (GAP_TIME)
    ) u_gap_timer (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .en  (w_in_wait),
        .tc  (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_single    <= 1'b0;
            r_double    <= 1'b0;
            r_click_cnt <= '0;
        end else begin
            r_single <= 1'b0;
            r_double <= 1'b0;
            if (key_pulse) begin
                r_click_cnt <= r_click_cnt + 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (key_pulse) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    // A press on the terminal cycle still counts as a double click.
                    if (key_pulse) begin
                        r_double <= 1'b1;
                        r_state  <= IDLE;
                    end else if (w_tc) begin
                        r_single <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign single_click = r_single;
    assign double_click = r_double;
    assign busy         = w_in_wait;
    assign click_cnt    = r_click_cnt;

endmodule : key_click_decode
`default_nettype wire

// File: tb/tb_key_click_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_click_decode
// Purpose  : Directed, scoreboard-checked bench for key_click_decode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_click_decode;

    localparam int c_gap   = key_pkg::c_gap_time_sim;
    localparam int c_cnt_w = 8;

    logic               clk;
    logic               rst;
    logic               key_pulse;
    logic               single_click;
    logic               double_click;
    logic               busy;
    logic [c_cnt_w-1:0] click_cnt;

    key_click_decode #(
        .GAP_TIME (c_gap),
        .CNT_W    (c_cnt_w)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .key_pulse    (key_pulse),
        .single_click (single_click),
        .double_click (double_click),
        .busy         (busy),
        .click_cnt    (click_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit dbl;
    } ev_t;

    ev_t              sb[$];
    int               n_cmp;
    int               n_err;
    int               cyc;
    bit               m_open;
    int               m_start;
    logic [c_cnt_w-1:0] m_cnt;
    int               seen_single;
    int               seen_double;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive the pulse, advance the timing model, compare just after the edge.
    task automatic tick(input logic p);
        ev_t ev;
        logic exp_s;
        logic exp_d;
        key_pulse = p;
        @(posedge clk);
        cyc++;
        if (p) m_cnt = m_cnt + 1'b1;
        if (m_open) begin
            if (p) begin
                sb.push_back('{cyc: cyc, dbl: 1'b1});
                m_open = 1'b0;
            end else if (cyc - m_start == c_gap) begin
                sb.push_back('{cyc: cyc, dbl: 1'b0});
                m_open = 1'b0;
            end
        end else if (p) begin
            m_open  = 1'b1;
            m_start = cyc;
        end
        #1;
        exp_s = 1'b0;
        exp_d = 1'b0;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            ev    = sb.pop_front();
            exp_s = !ev.dbl;
            exp_d = ev.dbl;
        end
        chk("single_click", 32'(single_click), 32'(exp_s));
        chk("double_click", 32'(double_click), 32'(exp_d));
        chk("busy",         32'(busy),         32'(m_open));
        chk("click_cnt",    32'(click_cnt),    32'(m_cnt));
        seen_single += int'(single_click);
        seen_double += int'(double_click);
        key_pulse = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".single"}, 32'(single_click), 32'd0);
        chk({tag, ".double"}, 32'(double_click), 32'd0);
        chk({tag, ".busy"},   32'(busy),         32'd0);
        chk({tag, ".cnt"},    32'(click_cnt),    32'd0);
    endtask

    task automatic model_clear();
        m_open = 1'b0;
        m_cnt  = '0;
        sb.delete();
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        cyc         = 0;
        m_start     = 0;
        seen_single = 0;
        seen_double = 0;
        model_clear();
        key_pulse   = 1'b0;

        // 1: reset, then one isolated press
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        tick(1'b1);
        idle(12);
        chk("t1.singles", 32'(seen_single), 32'd1);

        // 2: pulses at E0 and E0+3
        tick(1'b1); idle(2); tick(1'b1);
        idle(12);
        chk("t2.doubles", 32'(seen_double), 32'd1);
        chk("t2.singles", 32'(seen_single), 32'd1);

        // 3a: second press on the last window cycle (E0+8)
        tick(1'b1); idle(c_gap - 1); tick(1'b1);
        idle(12);
        chk("t3a.doubles", 32'(seen_double), 32'd2);
        chk("t3a.singles", 32'(seen_single), 32'd1);

        // 3b: second press one cycle late (E0+9) opens a fresh window
        tick(1'b1); idle(c_gap); tick(1'b1);
        idle(12);
        chk("t3b.singles", 32'(seen_single), 32'd3);

        // 4: triple click
        tick(1'b1); idle(1); tick(1'b1); idle(1); tick(1'b1);
        idle(12);
        chk("t4.doubles", 32'(seen_double), 32'd3);
        chk("t4.singles", 32'(seen_single), 32'd4);

        // 5: async reset mid-window
        tick(1'b1); idle(3);
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        chk("t5.singles", 32'(seen_single), 32'd4);
        chk("t5.doubles", 32'(seen_double), 32'd3);

        // 6: 256 isolated presses wrap the counter
        seen_single = 0;
        seen_double = 0;
        for (int k = 0; k < 256; k++) begin
            tick(1'b1);
            idle(c_gap + 1);
        end
        chk("t6.singles", 32'(seen_single), 32'd256);
        chk("t6.doubles", 32'(seen_double), 32'd0);
        chk("t6.cnt_wrap", 32'(click_cnt), 32'd0);
        chk("sb.drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_key_click_decode
`default_nettype wire
